trig_step_sequencer: RTL and testbench
======================================

# trig_step_sequencer

Trigger-driven output sequencer that plays a programmed table of signed 16-bit levels, each held for a programmable dwell, onto one instrument output channel. It sits between the instrument's control/status register words and one of `outputa`..`outputd`, and is armed and configured entirely from control words. A trigger on `exttrig` starts playback. Outputs ready-to-pack status words.

## Interface
- `DEPTH`, 16: number of table entries, power of two, 2..256.
- `AW`, $clog2(DEPTH): table address width.
- `clk`  in  1: sole clock.
- `reset`  in  1: **synchronous, active-high reset.**
- `arm`  in  1: level-sensitive; high arms/permits running, low aborts to IDLE.
- `exttrig`  in  1: synchronous trigger; rising edge starts a run.
- `num_steps`  in  AW+1: steps per pass; 0 treated as 1, >DEPTH clamped to DEPTH.
- `dwell`  in  32: cycles per step; 0 treated as 1.
- `loops`  in  16: passes per run; 0 = continuous until `arm` drops.
- `idle_level`  in  16 signed: output value when not running.
- `tbl_we`  in  1: table write strobe.
- `tbl_addr`  in  AW: table write address.
- `tbl_data`  in  16 signed: table write data.
- `dout`  out  16 signed: sequenced output.
- `busy`  out  1: high in RUN.
- `step_stb`  out  1: one-cycle pulse on every step change, including the first step.
- `done`  out  1: one-cycle pulse when a finite run completes.
- `status`  out  32: {state[1:0], 6'b0, step_idx[7:0], trig_count[7:0], missed_count[7:0]}.

## Operation
- States: IDLE, ARMED, RUN.
- IDLE -> ARMED when `arm`=1. ARMED -> RUN on trigger rise. RUN -> ARMED when the final step of the final pass finishes, with a `done` pulse. Any state -> IDLE when `arm`=0.
- Trigger rise = `exttrig`=1 and previous-cycle `exttrig`=0; the edge register resets to 1, so a trigger held high through reset does not fire.
- On trigger, `num_steps`, `dwell`, `loops` are latched. Mid-run changes take effect on the next run.
- RUN: `dout` = table[step_idx]. A dwell counter counts `dwell` cycles; then step_idx increments. After step num_steps-1, step_idx wraps to 0 and the pass counter increments.
- Table writes are accepted in any state. A write to the entry currently playing appears on `dout` the cycle after the write.
- Trigger rise while RUN is ignored and increments `missed_count`. Trigger rise in ARMED increments `trig_count`. Both counts saturate at 255 and clear only on `reset`.
- `arm`=0 and trigger rise in the same cycle: abort wins and nothing is counted.
- Dwell counter is 32-bit. Pass counter is 16-bit. Arithmetic is unsigned; no wrap is possible within the clamped ranges.

## Timing
- Reset values: state IDLE, `dout`=0, `busy`=0, `step_stb`=0, `done`=0, `status`=0, all counters 0. Table contents are not reset.
- Outside reset and outside RUN, `dout` = registered `idle_level`.
- All outputs are registered.
- If `exttrig` is sampled low at edge k-1 and high at edge k in ARMED, then at edge k: `dout`=table[0], `busy`=1, `step_stb`=1.
- Each step occupies exactly `dwell` cycles. A run of S steps, D dwell and L loops is S·D·L cycles long.
- `done` and `busy`=0 assert on the edge after the last step's final dwell cycle, and `dout` returns to `idle_level` on that same edge.
- Abort: `busy`=0 and `dout`=`idle_level` on the edge that samples `arm`=0.

## Structure
- Package `trig_seq_pkg`: state enum `seq_state_t`, status field bit positions, `LEVEL_W`=16.
- Sub-module `seq_level_table`: DEPTH×16 register file with synchronous write and registered read, addressed by the next step_idx so the read lines up with the output edge.
- The controller FSM, counters and status packing live in `trig_step_sequencer`.

## Test plan
- Table 0..3 = 100, -200, 300, -400; num_steps=4, dwell=3, loops=1, arm=1; one trigger -> `dout` = 100,100,100, -200×3, 300×3, -400×3 starting on the trigger edge; `done` at cycle 12; `dout` returns to idle_level; `trig_count`=1.
- loops=0, dwell=1, num_steps=2 -> output alternates between table[0] and table[1] indefinitely. Drop `arm` at cycle 50 -> IDLE on that edge, `busy`=0, no `done`.
- Trigger pulses every 5 cycles during a 40-cycle run -> `missed_count` increments once per extra rise; the run is unaffected.
- dwell=0, num_steps=0 -> one step of 1 cycle. num_steps=DEPTH+5 -> exactly DEPTH steps.
- `arm` low and trigger rise in the same cycle -> state IDLE, counts unchanged. `reset` asserted mid-run -> all outputs 0 on the next edge.
- Write table[1]=7 while step 1 is playing -> `dout`=7 on the next cycle.

Source files
------------

// File: rtl/trig_seq_pkg.sv
// rtl/trig_seq_pkg.sv - shared types and constants for the trigger step sequencer
//
// Purpose: state encoding, status word field positions, level width and a
//          saturating 8-bit increment shared by the sequencer and its table.
package trig_seq_pkg;

  localparam int LEVEL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_t;

  // status = {state[1:0], 6'b0, step_idx[7:0], trig_count[7:0], missed_count[7:0]}
  localparam int STATUS_STATE_LSB  = 30;
  localparam int STATUS_STEP_LSB   = 16;
  localparam int STATUS_TRIG_LSB   = 8;
  localparam int STATUS_MISSED_LSB = 0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seq_level_table.sv
// rtl/seq_level_table.sv - level table register file with registered, output-aligned read
//
// Purpose: DEPTH x LEVEL_W storage of output levels. The read register is the
//          sequencer's output register: it loads the addressed entry when the
//          sequencer will be running after this edge, otherwise idle_level.
// Ports:
//   clk, reset      clock and synchronous active-high reset (read register only)
//   we, waddr, wdata  synchronous table write, accepted in any state
//   rd_en           sequencer is in RUN after this edge
//   raddr           step index that will be playing after this edge
//   idle_level      value to present when not running
//   rd_data         registered output level
module seq_level_table
  import trig_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic signed [LEVEL_W-1:0] wdata,
  input  logic                      rd_en,
  input  logic [AW-1:0]             raddr,
  input  logic signed [LEVEL_W-1:0] idle_level,
  output logic signed [LEVEL_W-1:0] rd_data
);

  logic signed [LEVEL_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // No write bypass: a write to the playing entry shows up one edge after
  // the write edge, when the register re-reads the updated entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[raddr];
    end else begin
      rd_data <= idle_level;
    end
  end

endmodule

// File: rtl/trig_step_sequencer.sv
// rtl/trig_step_sequencer.sv - trigger-started playback of a level table with per-step dwell
//
// Purpose: IDLE/ARMED/RUN controller. A trigger rise in ARMED latches the run
//          configuration and plays table[0..S-1], each for D cycles, L passes
//          (L=0 plays until arm drops). Counts accepted and missed triggers.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   arm                     high permits running, low aborts to IDLE
//   exttrig                 trigger input, rising edge starts a run
//   num_steps, dwell, loops run configuration, latched on trigger
//   idle_level              output level when not running
//   tbl_we/tbl_addr/tbl_data  level table write port
//   dout                    sequenced output level
//   busy                    high while running
//   step_stb                pulse on each step change, including the first
//   done                    pulse when a finite run completes
//   status                  {state, 6'b0, step_idx, trig_count, missed_count}
module trig_step_sequencer
  import trig_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      exttrig,
  input  logic [AW:0]               num_steps,
  input  logic [31:0]               dwell,
  input  logic [15:0]               loops,
  input  logic signed [LEVEL_W-1:0] idle_level,
  input  logic                      tbl_we,
  input  logic [AW-1:0]             tbl_addr,
  input  logic signed [LEVEL_W-1:0] tbl_data,
  output logic signed [LEVEL_W-1:0] dout,
  output logic                      busy,
  output logic                      step_stb,
  output logic                      done,
  output logic [31:0]               status
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_S   = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  seq_state_t    state;
  logic [AW-1:0] step_idx;
  logic [31:0]   dwell_cnt;
  logic [15:0]   pass_cnt;
  logic [AW-1:0] last_idx_q;
  logic [31:0]   dwell_m1_q;
  logic [15:0]   loops_q;
  logic          trig_q;
  logic [7:0]    trig_count;
  logic [7:0]    missed_count;

  logic          trig_rise;
  logic [AW:0]   steps_eff;
  logic [AW-1:0] last_idx_in;
  logic [31:0]   dwell_m1_in;
  logic          dwell_done;
  logic          step_last;
  logic          pass_last;
  logic          run_end;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  assign trig_rise = exttrig & ~trig_q;

  // Configuration is stored as "last index" / "dwell minus one" so the
  // run-time compares need no arithmetic.
  always_comb begin
    steps_eff = num_steps;
    if (num_steps == '0) begin
      steps_eff = ONE_S;
    end else if (num_steps > DEPTH_W) begin
      steps_eff = DEPTH_W;
    end
    last_idx_in = AW'(steps_eff - ONE_S);
    dwell_m1_in = (dwell == 32'd0) ? 32'd0 : dwell - 32'd1;
  end

  assign dwell_done = (dwell_cnt == dwell_m1_q);
  assign step_last  = (step_idx == last_idx_q);
  assign pass_last  = (loops_q != 16'd0) && (pass_cnt == loops_q - 16'd1);
  assign run_end    = dwell_done && step_last && pass_last;

  // Step index that will be playing after this edge; feeds the table's
  // registered read so the new level appears on the same edge as step_stb.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = step_idx;
    if (arm) begin
      if (state == ST_ARMED && trig_rise) begin
        rd_en   = 1'b1;
        rd_addr = '0;
      end else if (state == ST_RUN) begin
        rd_en = !run_end;
        if (dwell_done) begin
          rd_addr = step_last ? '0 : step_idx + IDX_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      step_idx     <= '0;
      dwell_cnt    <= '0;
      pass_cnt     <= '0;
      last_idx_q   <= '0;
      dwell_m1_q   <= '0;
      loops_q      <= '0;
      trig_q       <= 1'b1;  // a trigger held high through reset must not fire
      trig_count   <= '0;
      missed_count <= '0;
      busy         <= 1'b0;
      step_stb     <= 1'b0;
      done         <= 1'b0;
    end else begin
      trig_q   <= exttrig;
      step_stb <= 1'b0;
      done     <= 1'b0;
      if (!arm) begin
        // Abort wins over any trigger in the same cycle; nothing is counted.
        state     <= ST_IDLE;
        busy      <= 1'b0;
        step_idx  <= '0;
        dwell_cnt <= '0;
        pass_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ARMED;
          end
          ST_ARMED: begin
            if (trig_rise) begin
              state      <= ST_RUN;
              busy       <= 1'b1;
              step_stb   <= 1'b1;
              step_idx   <= '0;
              dwell_cnt  <= '0;
              pass_cnt   <= '0;
              last_idx_q <= last_idx_in;
              dwell_m1_q <= dwell_m1_in;
              loops_q    <= loops;
              trig_count <= sat_inc8(trig_count);
            end
          end
          ST_RUN: begin
            if (trig_rise) begin
              missed_count <= sat_inc8(missed_count);
            end
            if (dwell_done) begin
              dwell_cnt <= '0;
              if (step_last) begin
                step_idx <= '0;
                if (pass_last) begin
                  state    <= ST_ARMED;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pass_cnt <= '0;
                end else begin
                  step_stb <= 1'b1;
                  // Continuous mode never uses the pass count; keep it still.
                  if (loops_q != 16'd0) begin
                    pass_cnt <= pass_cnt + 16'd1;
                  end
                end
              end else begin
                step_idx <= step_idx + IDX_ONE;
                step_stb <= 1'b1;
              end
            end else begin
              dwell_cnt <= dwell_cnt + 32'd1;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    status = '0;
    status[STATUS_STATE_LSB +: 2]  = state;
    status[STATUS_STEP_LSB +: 8]   = 8'(step_idx);
    status[STATUS_TRIG_LSB +: 8]   = trig_count;
    status[STATUS_MISSED_LSB +: 8] = missed_count;
  end

  seq_level_table #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .we         (tbl_we),
    .waddr      (tbl_addr),
    .wdata      (tbl_data),
    .rd_en      (rd_en),
    .raddr      (rd_addr),
    .idle_level (idle_level),
    .rd_data    (dout)
  );

endmodule

// File: tb/tb_trig_step_sequencer.sv
// tb/tb_trig_step_sequencer.sv - self-checking bench for trig_step_sequencer
module tb_trig_step_sequencer;
  import trig_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               arm = 1'b0;
  logic               exttrig = 1'b0;
  logic [AW:0]        num_steps = '0;
  logic [31:0]        dwell = '0;
  logic [15:0]        loops = '0;
  logic signed [15:0] idle_level = '0;
  logic               tbl_we = 1'b0;
  logic [AW-1:0]      tbl_addr = '0;
  logic signed [15:0] tbl_data = '0;
  logic signed [15:0] dout;
  logic               busy;
  logic               step_stb;
  logic               done;
  logic [31:0]        status;

  always #5 clk = ~clk;

  trig_step_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .exttrig    (exttrig),
    .num_steps  (num_steps),
    .dwell      (dwell),
    .loops      (loops),
    .idle_level (idle_level),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .dout       (dout),
    .busy       (busy),
    .step_stb   (step_stb),
    .done       (done),
    .status     (status)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic signed [15:0] tbl_m [DEPTH];
  int trig_m = 0;
  int missed_m = 0;

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [31:0] exp_status(input logic [1:0] st, input int idx);
    return {st, 6'b0, 8'(idx), 8'(trig_m), 8'(missed_m)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tbl(input int addr, input logic signed [15:0] data);
    tbl_we = 1'b1;
    tbl_addr = AW'(addr);
    tbl_data = data;
    tick();
    tbl_we = 1'b0;
    tbl_m[addr] = data;
  endtask

  // Plays one finite run and checks every cycle against the expected
  // schedule: step k of pass p occupies cycles (p*S+k)*D .. (p*S+k)*D+D-1.
  task automatic play_run(input int ns, input int dw, input int lp, input int pulse_p,
                          input int wr_at, input int wr_addr, input logic signed [15:0] wr_data,
                          input string name);
    int s_eff, d_eff, total, idx;
    logic signed [15:0] e_dout;
    s_eff = (ns == 0) ? 1 : ((ns > DEPTH) ? DEPTH : ns);
    d_eff = (dw == 0) ? 1 : dw;
    total = s_eff * d_eff * lp;
    arm = 1'b1;
    exttrig = 1'b0;
    tick();
    n_cmp++;
    if (status !== exp_status(ST_ARMED, 0) || dout !== idle_level) begin
      n_fail++;
      $display("FAIL %s armed status=%h dout=%0d exp status=%h dout=%0d", name, status, dout,
               exp_status(ST_ARMED, 0), idle_level);
    end
    num_steps = (AW+1)'(ns);
    dwell = dw;
    loops = 16'(lp);
    exttrig = 1'b1;
    tick();
    trig_m = sat8(trig_m + 1);
    for (int t = 0; t <= total; t++) begin
      if (t > 0) begin
        exttrig = (pulse_p > 1 && t < total && (t % pulse_p) == 0);
        tbl_we = (t == wr_at);
        tbl_addr = AW'(wr_addr);
        tbl_data = wr_data;
        // Configuration changes mid-run must not affect this run.
        num_steps = (AW+1)'($urandom);
        dwell = $urandom_range(0, 7);
        loops = 16'($urandom_range(0, 3));
        tick();
        if (exttrig) missed_m = sat8(missed_m + 1);
      end
      if (t < total) begin
        idx = (t / d_eff) % s_eff;
        e_dout = tbl_m[idx];
        n_cmp++;
        if (dout !== e_dout) begin
          n_fail++;
          $display("FAIL %s dout t=%0d got %0d exp %0d", name, t, dout, e_dout);
        end
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || step_stb !== ((t % d_eff) == 0)) begin
          n_fail++;
          $display("FAIL %s flags t=%0d busy=%b done=%b stb=%b exp stb=%b", name, t, busy, done,
                   step_stb, ((t % d_eff) == 0));
        end
        n_cmp++;
        if (status !== exp_status(ST_RUN, idx)) begin
          n_fail++;
          $display("FAIL %s status t=%0d got %h exp %h", name, t, status, exp_status(ST_RUN, idx));
        end
        if (t == wr_at) tbl_m[wr_addr] = wr_data;
      end else begin
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || step_stb !== 1'b0 || dout !== idle_level) begin
          n_fail++;
          $display("FAIL %s end t=%0d done=%b busy=%b stb=%b dout=%0d exp done=1 busy=0 dout=%0d",
                   name, t, done, busy, step_stb, dout, idle_level);
        end
        n_cmp++;
        if (status !== exp_status(ST_ARMED, 0)) begin
          n_fail++;
          $display("FAIL %s end status got %h exp %h", name, status, exp_status(ST_ARMED, 0));
        end
      end
    end
    tbl_we = 1'b0;
    exttrig = 1'b0;
  endtask

  // Continuous 2-step, 1-cycle run; then arm drops (optionally with a trigger rise).
  task automatic test_continuous(input int ncyc, input int pulse_p, input bit trig_at_drop,
                                 input string name);
    arm = 1'b1;
    exttrig = 1'b0;
    tick();
    num_steps = 2;
    dwell = 1;
    loops = 0;
    exttrig = 1'b1;
    tick();
    trig_m = sat8(trig_m + 1);
    for (int t = 0; t < ncyc; t++) begin
      if (t > 0) begin
        exttrig = (pulse_p > 1 && (t % pulse_p) == 0);
        tick();
        if (exttrig) missed_m = sat8(missed_m + 1);
      end
      n_cmp++;
      if (dout !== tbl_m[t % 2] || busy !== 1'b1 || step_stb !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s t=%0d dout=%0d busy=%b stb=%b done=%b exp dout=%0d", name, t, dout, busy,
                 step_stb, done, tbl_m[t % 2]);
      end
    end
    arm = 1'b0;
    exttrig = trig_at_drop;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== idle_level || status !== exp_status(ST_IDLE, 0)) begin
      n_fail++;
      $display("FAIL %s abort busy=%b done=%b dout=%0d status=%h exp dout=%0d status=%h", name,
               busy, done, dout, status, idle_level, exp_status(ST_IDLE, 0));
    end
    exttrig = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    arm = 1'b1;
    exttrig = 1'b1;
    idle_level = 16'sd55;
    repeat (3) tick();
    n_cmp++;
    if (dout !== 16'sd0 || busy !== 1'b0 || step_stb !== 1'b0 || done !== 1'b0 || status !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state dout=%0d busy=%b stb=%b done=%b status=%h exp all 0", dout, busy,
               step_stb, done, status);
    end
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b0 || status !== exp_status(ST_ARMED, 0) || dout !== idle_level) begin
      n_fail++;
      $display("FAIL reset_held_trig busy=%b status=%h dout=%0d exp busy=0 status=%h dout=%0d", busy,
               status, dout, exp_status(ST_ARMED, 0), idle_level);
    end
    exttrig = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < DEPTH; i++) write_tbl(i, 16'($urandom));
    write_tbl(0, 16'sd100);
    write_tbl(1, -16'sd200);
    write_tbl(2, 16'sd300);
    write_tbl(3, -16'sd400);
    idle_level = -16'sd7;
    play_run(4, 3, 1, 0, -1, 0, 16'sd0, "basic");
    n_cmp++;
    if (status[15:8] !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_trig_count got %0d exp 1", status[15:8]);
    end
  endtask

  task automatic test_missed();
    play_run(8, 5, 1, 5, -1, 0, 16'sd0, "missed");
    n_cmp++;
    if (status[7:0] !== 8'd7) begin
      n_fail++;
      $display("FAIL missed_count got %0d exp 7", status[7:0]);
    end
  endtask

  task automatic test_table_write();
    // Step 1 plays at t=4..7; the write lands on edge 5, visible from edge 6.
    play_run(4, 4, 1, 0, 5, 1, 16'sd7, "tbl_write");
  endtask

  task automatic test_clamp();
    play_run(0, 0, 1, 0, -1, 0, 16'sd0, "zero_cfg");
    play_run(DEPTH + 5, 1, 1, 0, -1, 0, 16'sd0, "over_depth");
    play_run(1, 2, 3, 0, -1, 0, 16'sd0, "one_step_loops");
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) write_tbl(i, 16'($urandom));
      idle_level = 16'($urandom);
      play_run($urandom_range(0, DEPTH + 3), $urandom_range(0, 4), $urandom_range(1, 3),
               ($urandom_range(0, 1) == 1) ? $urandom_range(2, 7) : 0,
               $urandom_range(1, 12), $urandom_range(0, DEPTH - 1), 16'($urandom), "random");
    end
  endtask

  task automatic test_abort_trig();
    arm = 1'b1;
    exttrig = 1'b0;
    tick();
    arm = 1'b0;
    exttrig = 1'b1;
    tick();
    n_cmp++;
    if (status !== exp_status(ST_IDLE, 0) || busy !== 1'b0 || dout !== idle_level) begin
      n_fail++;
      $display("FAIL abort_trig_armed status=%h busy=%b exp status=%h busy=0", status, busy,
               exp_status(ST_IDLE, 0));
    end
    exttrig = 1'b0;
    tick();
    test_continuous(10, 0, 1'b1, "abort_trig_run");
  endtask

  task automatic test_saturation();
    arm = 1'b1;
    exttrig = 1'b0;
    tick();
    num_steps = 1;
    dwell = 1;
    loops = 1;
    for (int i = 0; i < 260; i++) begin
      exttrig = 1'b1;
      tick();
      trig_m = sat8(trig_m + 1);
      exttrig = 1'b0;
      tick();
    end
    n_cmp++;
    if (status[15:8] !== 8'd255 || status[15:8] !== 8'(trig_m)) begin
      n_fail++;
      $display("FAIL trig_saturate got %0d exp %0d", status[15:8], trig_m);
    end
    test_continuous(600, 2, 1'b0, "missed_saturate");
    n_cmp++;
    if (status[7:0] !== 8'd255) begin
      n_fail++;
      $display("FAIL missed_saturate got %0d exp 255", status[7:0]);
    end
  endtask

  task automatic test_reset_midrun();
    arm = 1'b1;
    exttrig = 1'b0;
    tick();
    num_steps = 4;
    dwell = 3;
    loops = 2;
    exttrig = 1'b1;
    tick();
    exttrig = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b1 || step_stb !== 1'b1 || dout !== tbl_m[1]) begin
      n_fail++;
      $display("FAIL midrun_pre busy=%b stb=%b dout=%0d exp busy=1 stb=1 dout=%0d", busy, step_stb,
               dout, tbl_m[1]);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (dout !== 16'sd0 || busy !== 1'b0 || step_stb !== 1'b0 || done !== 1'b0 || status !== 32'd0) begin
      n_fail++;
      $display("FAIL midrun_reset dout=%0d busy=%b stb=%b done=%b status=%h exp all 0", dout, busy,
               step_stb, done, status);
    end
    reset = 1'b0;
    trig_m = 0;
    missed_m = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_missed();
    test_table_write();
    test_clamp();
    test_random_runs();
    test_continuous(50, 0, 1'b0, "continuous");
    test_abort_trig();
    test_saturation();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
